// File: rtl/sdram_wbaxi_bridge_if.sv
// Bus bundle for sdram_wbaxi_bridge: pipelined Wishbone slave side plus AXI4 master side.
// Modport slave is the bridge's view; modport master is the system/memory environment's view.
interface sdram_wbaxi_bridge_if #(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int AXI_DW  = 128,
  parameter int AXI_AW  = AW + $clog2(DW/8),
  parameter int AXI_IDW = 1
);
  logic                  i_wb_cyc, i_wb_stb, i_wb_we;
  logic [AW-1:0]         i_wb_addr;
  logic [DW-1:0]         i_wb_data;
  logic [DW/8-1:0]       i_wb_sel;
  logic                  o_wb_stall, o_wb_ack, o_wb_err;
  logic [DW-1:0]         o_wb_data;

  logic                  o_axi_awvalid, i_axi_awready;
  logic [AXI_AW-1:0]     o_axi_awaddr;
  logic [AXI_IDW-1:0]    o_axi_awid;
  logic [7:0]            o_axi_awlen;
  logic [2:0]            o_axi_awsize;
  logic [1:0]            o_axi_awburst;
  logic                  o_axi_awlock;
  logic [3:0]            o_axi_awcache;
  logic [2:0]            o_axi_awprot;
  logic [3:0]            o_axi_awqos;

  logic                  o_axi_wvalid, i_axi_wready;
  logic [AXI_DW-1:0]     o_axi_wdata;
  logic [AXI_DW/8-1:0]   o_axi_wstrb;
  logic                  o_axi_wlast;

  logic                  i_axi_bvalid, o_axi_bready;
  logic [AXI_IDW-1:0]    i_axi_bid;
  logic [1:0]            i_axi_bresp;

  logic                  o_axi_arvalid, i_axi_arready;
  logic [AXI_AW-1:0]     o_axi_araddr;
  logic [AXI_IDW-1:0]    o_axi_arid;
  logic [7:0]            o_axi_arlen;
  logic [2:0]            o_axi_arsize;
  logic [1:0]            o_axi_arburst;
  logic                  o_axi_arlock;
  logic [3:0]            o_axi_arcache;
  logic [2:0]            o_axi_arprot;
  logic [3:0]            o_axi_arqos;

  logic                  i_axi_rvalid, o_axi_rready;
  logic [AXI_IDW-1:0]    i_axi_rid;
  logic [AXI_DW-1:0]     i_axi_rdata;
  logic [1:0]            i_axi_rresp;
  logic                  i_axi_rlast;

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_stall, o_wb_ack, o_wb_err, o_wb_data,
    output o_axi_awvalid, o_axi_awaddr, o_axi_awid, o_axi_awlen, o_axi_awsize, o_axi_awburst,
           o_axi_awlock, o_axi_awcache, o_axi_awprot, o_axi_awqos,
    input  i_axi_awready,
    output o_axi_wvalid, o_axi_wdata, o_axi_wstrb, o_axi_wlast,
    input  i_axi_wready,
    input  i_axi_bvalid, i_axi_bid, i_axi_bresp,
    output o_axi_bready,
    output o_axi_arvalid, o_axi_araddr, o_axi_arid, o_axi_arlen, o_axi_arsize, o_axi_arburst,
           o_axi_arlock, o_axi_arcache, o_axi_arprot, o_axi_arqos,
    input  i_axi_arready,
    input  i_axi_rvalid, i_axi_rid, i_axi_rdata, i_axi_rresp, i_axi_rlast,
    output o_axi_rready
  );

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_stall, o_wb_ack, o_wb_err, o_wb_data,
    input  o_axi_awvalid, o_axi_awaddr, o_axi_awid, o_axi_awlen, o_axi_awsize, o_axi_awburst,
           o_axi_awlock, o_axi_awcache, o_axi_awprot, o_axi_awqos,
    output i_axi_awready,
    input  o_axi_wvalid, o_axi_wdata, o_axi_wstrb, o_axi_wlast,
    output i_axi_wready,
    output i_axi_bvalid, i_axi_bid, i_axi_bresp,
    input  o_axi_bready,
    input  o_axi_arvalid, o_axi_araddr, o_axi_arid, o_axi_arlen, o_axi_arsize, o_axi_arburst,
           o_axi_arlock, o_axi_arcache, o_axi_arprot, o_axi_arqos,
    output i_axi_arready,
    output i_axi_rvalid, i_axi_rid, i_axi_rdata, i_axi_rresp, i_axi_rlast,
    input  o_axi_rready
  );
endinterface

// File: rtl/sdram_wbaxi_bridge.sv
// Pipelined Wishbone slave to single-beat AXI4 master with lane packing and in-order acks.
// Optional macro SDRAM_CALIB_GATE_EN: stall the Wishbone side until i_calib_done is high.
module sdram_wbaxi_bridge #(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int AXI_DW  = 128,
  parameter int AXI_AW  = AW + $clog2(DW/8),
  parameter int AXI_IDW = 1,
  parameter int LGFIFO  = 5
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_calib_done,
  sdram_wbaxi_bridge_if.slave bus
);
  localparam int NL    = AXI_DW / DW;
  localparam int LW    = $clog2(NL);
  localparam int LWX   = (LW > 0) ? LW : 1;
  localparam int SW    = DW / 8;
  localparam int BW    = $clog2(SW);
  localparam int DEPTH = 1 << LGFIFO;
  localparam logic [LGFIFO:0] CNT_FULL = {1'b1, {LGFIFO{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

  state_t               state_q, state_d;
  logic [LGFIFO:0]      cnt_q, cnt_d;
  logic                 awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic [AXI_AW-1:0]    awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [AXI_DW-1:0]    wdata_q, wdata_d;
  logic [AXI_DW/8-1:0]  wstrb_q, wstrb_d;
  logic                 ack_q, ack_d, err_q, err_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic [LGFIFO-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LWX-1:0]       lane_mem [DEPTH];

  logic                 gate, stall, accept, mismatch, pending;
  logic                 resp_take, resp_err, report, pop;
  logic [LWX-1:0]       lane, head_lane;
  logic [AXI_AW-1:0]    beat_addr;

`ifdef SDRAM_CALIB_GATE_EN
  assign gate = !i_calib_done;
`else
  logic unused_calib;
  assign unused_calib = i_calib_done;
  assign gate = 1'b0;
`endif

  logic unused_resp;
  assign unused_resp = &{1'b0, bus.i_axi_bid, bus.i_axi_rid, bus.i_axi_rlast,
                         bus.i_axi_bresp[0], bus.i_axi_rresp[0]};

  assign lane      = (NL > 1) ? bus.i_wb_addr[LWX-1:0] : '0;
  assign beat_addr = AXI_AW'(bus.i_wb_addr >> LW) << (LW + BW);
  assign head_lane = lane_mem[rd_ptr_q];
  assign pending   = awvalid_q || wvalid_q || arvalid_q;
  assign mismatch  = (state_q == S_WRITE && !bus.i_wb_we) || (state_q == S_READ && bus.i_wb_we);

  // Stall follows ready combinationally so a handshake cycle can also accept the next request.
  assign stall = !i_reset_n || (state_q == S_DRAIN) || (cnt_q == CNT_FULL) || mismatch
              || (awvalid_q && !bus.i_axi_awready) || (wvalid_q && !bus.i_axi_wready)
              || (arvalid_q && !bus.i_axi_arready) || gate;
  assign accept = bus.i_wb_cyc && bus.i_wb_stb && !stall;

  // A response arriving with nothing outstanding is a protocol violation and is ignored.
  assign resp_take = (bus.i_axi_bvalid || bus.i_axi_rvalid) && (cnt_q != '0);
  assign resp_err  = bus.i_axi_rvalid ? bus.i_axi_rresp[1] : bus.i_axi_bresp[1];
  assign pop       = bus.i_axi_rvalid && (cnt_q != '0);
  assign report    = resp_take && bus.i_wb_cyc && (state_q != S_DRAIN);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    awvalid_d = awvalid_q && !bus.i_axi_awready;
    wvalid_d  = wvalid_q && !bus.i_axi_wready;
    arvalid_d = arvalid_q && !bus.i_axi_arready;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    if (accept && bus.i_wb_we) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      awaddr_d  = beat_addr;
      wdata_d   = {NL{bus.i_wb_data}};
      wstrb_d   = '0;
      wstrb_d[int'(lane)*SW +: SW] = bus.i_wb_sel;
    end
    if (accept && !bus.i_wb_we) begin
      arvalid_d = 1'b1;
      araddr_d  = beat_addr;
      wr_ptr_d  = wr_ptr_q + LGFIFO'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + LGFIFO'(1);
      rdata_d  = bus.i_axi_rdata[int'(head_lane)*DW +: DW];
    end

    if (accept && !resp_take)      cnt_d = cnt_q + (LGFIFO+1)'(1);
    else if (!accept && resp_take) cnt_d = cnt_q - (LGFIFO+1)'(1);

    if (report) begin
      err_d = resp_err;
      ack_d = !resp_err;
    end

    case (state_q)
      S_IDLE:  if (accept) state_d = bus.i_wb_we ? S_WRITE : S_READ;
      S_WRITE, S_READ: begin
        if (!bus.i_wb_cyc && (cnt_q != '0 || pending)) state_d = S_DRAIN;
        else if (report && resp_err)                   state_d = S_DRAIN;
        else if (cnt_d == '0 && !(awvalid_d || wvalid_d || arvalid_d)) state_d = S_IDLE;
      end
      default: if (cnt_q == '0 && !pending) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Lane FIFO storage needs no reset; only the pointers define its contents.
  always_ff @(posedge i_clk) begin
    if (accept && !bus.i_wb_we) lane_mem[wr_ptr_q] <= lane;
  end

  assign bus.o_wb_stall    = stall;
  assign bus.o_wb_ack      = ack_q;
  assign bus.o_wb_err      = err_q;
  assign bus.o_wb_data     = rdata_q;

  assign bus.o_axi_awvalid = awvalid_q;
  assign bus.o_axi_awaddr  = awaddr_q;
  assign bus.o_axi_awid    = '0;
  assign bus.o_axi_awlen   = 8'd0;
  assign bus.o_axi_awsize  = 3'($clog2(AXI_DW/8));
  assign bus.o_axi_awburst = 2'b01;
  assign bus.o_axi_awlock  = 1'b0;
  assign bus.o_axi_awcache = 4'h3;
  assign bus.o_axi_awprot  = 3'd0;
  assign bus.o_axi_awqos   = 4'd0;

  assign bus.o_axi_wvalid  = wvalid_q;
  assign bus.o_axi_wdata   = wdata_q;
  assign bus.o_axi_wstrb   = wstrb_q;
  assign bus.o_axi_wlast   = 1'b1;
  assign bus.o_axi_bready  = 1'b1;

  assign bus.o_axi_arvalid = arvalid_q;
  assign bus.o_axi_araddr  = araddr_q;
  assign bus.o_axi_arid    = '0;
  assign bus.o_axi_arlen   = 8'd0;
  assign bus.o_axi_arsize  = 3'($clog2(AXI_DW/8));
  assign bus.o_axi_arburst = 2'b01;
  assign bus.o_axi_arlock  = 1'b0;
  assign bus.o_axi_arcache = 4'h3;
  assign bus.o_axi_arprot  = 3'd0;
  assign bus.o_axi_arqos   = 4'd0;
  assign bus.o_axi_rready  = 1'b1;
endmodule

// File: tb/tb_sdram_wbaxi_bridge.sv
// Directed bench for sdram_wbaxi_bridge (AXI_DW=128, DW=32, LGFIFO=5) with hand-computed expectations.
module tb_sdram_wbaxi_bridge;
  localparam logic [127:0] RBEAT = {32'h0000_4444, 32'h0000_3333, 32'h0000_2222, 32'h0000_1111};

  logic clk = 1'b0;
  logic rst_n;
  logic calib;
  int   checks = 0;
  int   errors = 0;
  int   acks;
  logic will_acc;

  always #5 clk = ~clk;

  sdram_wbaxi_bridge_if #(.AW(26), .DW(32), .AXI_DW(128), .AXI_IDW(1)) bus ();

  sdram_wbaxi_bridge #(.AW(26), .DW(32), .AXI_DW(128), .AXI_IDW(1), .LGFIFO(5)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_calib_done(calib),
    .bus         (bus)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    calib = 1'b1;
    bus.i_wb_cyc = 0; bus.i_wb_stb = 0; bus.i_wb_we = 0;
    bus.i_wb_addr = '0; bus.i_wb_data = '0; bus.i_wb_sel = '0;
    bus.i_axi_awready = 1; bus.i_axi_wready = 1; bus.i_axi_arready = 1;
    bus.i_axi_bvalid = 0; bus.i_axi_bid = '0; bus.i_axi_bresp = 2'b00;
    bus.i_axi_rvalid = 0; bus.i_axi_rid = '0; bus.i_axi_rdata = '0;
    bus.i_axi_rresp = 2'b00; bus.i_axi_rlast = 1;

    // Reset state and constant AXI fields
    #1;
    check("rst_stall", bus.o_wb_stall, 1);
    check("rst_ack", bus.o_wb_ack, 0);
    check("rst_err", bus.o_wb_err, 0);
    check("rst_data", bus.o_wb_data, 0);
    check("rst_valids", {bus.o_axi_awvalid, bus.o_axi_wvalid, bus.o_axi_arvalid}, 0);
    check("const_ready", {bus.o_axi_bready, bus.o_axi_rready}, 2'b11);
    check("const_size_burst", {bus.o_axi_awsize, bus.o_axi_awburst, bus.o_axi_arsize, bus.o_axi_arburst}, 10'b100_01_100_01);
    check("const_cache", {bus.o_axi_awcache, bus.o_axi_arcache}, 8'h33);
    check("const_len_id", {bus.o_axi_awlen, bus.o_axi_arlen, bus.o_axi_awid, bus.o_axi_arid}, 0);
    step(); step();
    rst_n = 1'b1;
    #1;
    check("idle_stall", bus.o_wb_stall, 0);
    $display("reset: checks so far %0d", checks);

    // Single write, AW held off one cycle so W completes first
    bus.i_axi_awready = 0;
    bus.i_wb_cyc = 1; bus.i_wb_stb = 1; bus.i_wb_we = 1;
    bus.i_wb_addr = 26'h13; bus.i_wb_data = 32'hDEADBEEF; bus.i_wb_sel = 4'hC;
    #1 check("wr_accept_stall", bus.o_wb_stall, 0);
    step();
    bus.i_wb_stb = 0;
    check("wr_awvalid", bus.o_axi_awvalid, 1);
    check("wr_wvalid", bus.o_axi_wvalid, 1);
    check("wr_awaddr", bus.o_axi_awaddr, 28'h40);
    check("wr_wdata", bus.o_axi_wdata, {4{32'hDEADBEEF}});
    check("wr_wstrb", bus.o_axi_wstrb, 16'hC000);
    check("wr_wlast", bus.o_axi_wlast, 1);
    #1 check("wr_aw_blocked_stall", bus.o_wb_stall, 1);
    step();
    check("wr_aw_held", {bus.o_axi_awvalid, bus.o_axi_wvalid}, 2'b10);
    bus.i_axi_awready = 1;
    #1 check("wr_aw_ready_stall", bus.o_wb_stall, 0);
    step();
    check("wr_aw_done", bus.o_axi_awvalid, 0);
    check("wr_no_early_ack", bus.o_wb_ack, 0);
    bus.i_axi_bvalid = 1; bus.i_axi_bresp = 2'b00;
    step();
    bus.i_axi_bvalid = 0;
    check("wr_ack", {bus.o_wb_ack, bus.o_wb_err}, 2'b10);
    step();
    check("wr_ack_one_cycle", bus.o_wb_ack, 0);
    $display("write 0x13 sel=C: done");

    // Four back-to-back reads of one beat, lanes 0..3
    bus.i_wb_stb = 1; bus.i_wb_we = 0;
    for (int i = 0; i < 4; i++) begin
      bus.i_wb_addr = 26'(i);
      #1 check("rd4_no_stall", bus.o_wb_stall, 0);
      step();
    end
    bus.i_wb_stb = 0;
    check("rd4_araddr", bus.o_axi_araddr, 28'h0);
    bus.i_axi_rvalid = 1; bus.i_axi_rdata = RBEAT;
    step(); check("rd4_d0", {bus.o_wb_ack, bus.o_wb_data}, {1'b1, 32'h1111});
    step(); check("rd4_d1", {bus.o_wb_ack, bus.o_wb_data}, {1'b1, 32'h2222});
    step(); check("rd4_d2", {bus.o_wb_ack, bus.o_wb_data}, {1'b1, 32'h3333});
    step(); check("rd4_d3", {bus.o_wb_ack, bus.o_wb_data}, {1'b1, 32'h4444});
    bus.i_axi_rvalid = 0;
    step(); check("rd4_end", bus.o_wb_ack, 0);
    $display("four reads: done");

    // Outstanding limit: 32 writes accepted without B, the 33rd stalls
    bus.i_wb_stb = 1; bus.i_wb_we = 1; bus.i_wb_sel = 4'hF;
    for (int i = 0; i < 32; i++) begin
      bus.i_wb_addr = 26'(i);
      #1 check("full_fill", bus.o_wb_stall, 0);
      step();
    end
    bus.i_wb_addr = 26'd32;
    #1 check("full_stall", bus.o_wb_stall, 1);
    step();
    check("full_stall_held", bus.o_wb_stall, 1);
    bus.i_axi_bvalid = 1;
    acks = 0;
    for (int c = 0; c < 80; c++) begin
      #1 will_acc = bus.i_wb_stb && !bus.o_wb_stall;
      step();
      if (bus.o_wb_ack) acks++;
      if (will_acc) bus.i_wb_stb = 0;
    end
    bus.i_axi_bvalid = 0;
    check("full_acks", 128'(acks), 33);
    step();
    $display("outstanding limit: %0d acks", acks);

    // Read blocked behind three writes
    bus.i_wb_stb = 1; bus.i_wb_we = 1;
    for (int i = 0; i < 3; i++) begin
      bus.i_wb_addr = 26'(i);
      step();
    end
    bus.i_wb_we = 0; bus.i_wb_addr = 26'd5;
    #1 check("mix_rd_blocked", bus.o_wb_stall, 1);
    step();
    check("mix_rd_blocked2", bus.o_wb_stall, 1);
    bus.i_axi_bvalid = 1;
    step(); check("mix_b1", {bus.o_wb_ack, bus.o_wb_stall}, 2'b11);
    step(); check("mix_b2", {bus.o_wb_ack, bus.o_wb_stall}, 2'b11);
    step();
    bus.i_axi_bvalid = 0;
    check("mix_b3_ack", bus.o_wb_ack, 1);
    #1 check("mix_unblocked", {bus.o_wb_stall, bus.o_axi_arvalid}, 2'b00);
    step();
    bus.i_wb_stb = 0;
    check("mix_arvalid", bus.o_axi_arvalid, 1);
    check("mix_araddr", bus.o_axi_araddr, 28'h10);
    bus.i_axi_rvalid = 1;
    step();
    bus.i_axi_rvalid = 0;
    check("mix_rdata", {bus.o_wb_ack, bus.o_wb_data}, {1'b1, 32'h2222});
    step();
    $display("read after writes: done");

    // Abort with two reads outstanding, then a lane-3 read after the drain
    bus.i_wb_stb = 1; bus.i_wb_we = 0;
    bus.i_wb_addr = 26'd8; step();
    bus.i_wb_addr = 26'd9; step();
    bus.i_wb_stb = 0; bus.i_wb_cyc = 0;
    step();
    bus.i_wb_cyc = 1; bus.i_wb_stb = 1; bus.i_wb_addr = 26'd3;
    #1 check("drain_stall", bus.o_wb_stall, 1);
    bus.i_axi_rvalid = 1;
    step(); check("drain_r1", {bus.o_wb_ack, bus.o_wb_err, bus.o_wb_stall}, 3'b001);
    step(); check("drain_r2", {bus.o_wb_ack, bus.o_wb_err}, 2'b00);
    bus.i_axi_rvalid = 0;
    #1 check("drain_still", bus.o_wb_stall, 1);
    step();
    check("drain_done", bus.o_wb_stall, 0);
    step();
    bus.i_wb_stb = 0;
    check("post_drain_arvalid", bus.o_axi_arvalid, 1);
    bus.i_axi_rvalid = 1;
    step();
    bus.i_axi_rvalid = 0;
    check("post_drain_lane", {bus.o_wb_ack, bus.o_wb_data}, {1'b1, 32'h4444});
    step();
    $display("abort and drain: done");

    // Error on the second of three writes
    bus.i_wb_stb = 1; bus.i_wb_we = 1;
    for (int i = 0; i < 3; i++) begin
      bus.i_wb_addr = 26'(16 + i);
      step();
    end
    bus.i_wb_stb = 0;
    bus.i_axi_bvalid = 1; bus.i_axi_bresp = 2'b00;
    step(); check("err_b1", {bus.o_wb_ack, bus.o_wb_err}, 2'b10);
    bus.i_axi_bresp = 2'b10;
    step(); check("err_b2", {bus.o_wb_ack, bus.o_wb_err, bus.o_wb_stall}, 3'b011);
    bus.i_axi_bresp = 2'b00;
    step(); check("err_b3_dropped", {bus.o_wb_ack, bus.o_wb_err}, 2'b00);
    bus.i_axi_bvalid = 0;
    step(); check("err_quiet", {bus.o_wb_ack, bus.o_wb_err, bus.o_wb_stall}, 3'b000);
    $display("bus error: done");

    // Reset mid-transfer drops pending valids at once
    bus.i_axi_awready = 0;
    bus.i_wb_stb = 1; bus.i_wb_we = 1; bus.i_wb_addr = 26'd7;
    step();
    bus.i_wb_stb = 0;
    check("rst_mid_pending", bus.o_axi_awvalid, 1);
    rst_n = 1'b0;
    #1 check("rst_mid_drop", {bus.o_axi_awvalid, bus.o_axi_wvalid, bus.o_wb_stall}, 3'b001);
    step();
    rst_n = 1'b1; bus.i_axi_awready = 1;
    #1 check("rst_mid_release", bus.o_wb_stall, 0);
    $display("reset mid-transfer: done");

    // Calibration gate
    calib = 1'b0;
`ifdef SDRAM_CALIB_GATE_EN
    #1 check("calib_gate", bus.o_wb_stall, 1);
`else
    #1 check("calib_gate", bus.o_wb_stall, 0);
`endif
    calib = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
